// File: rtl/io_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : io_bus_arbiter
// Brief   : Serialises CPU and DMA accesses onto the single-ported IO register
//           block. DMA has priority. A starvation guard lets the CPU through
//           after a run of DMA grants, and dma_lock holds the bus for DMA bursts.
// Rev     : 1.0  initial release
// ============================================================================
module io_bus_arbiter #(
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk_mem,
    input  logic        rst_n,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [23:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ack,
    output logic [31:0] cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [23:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic        dma_lock,
    output logic        dma_ack,
    output logic [31:0] dma_rdata,
    output logic [23:0] io_addr,
    output logic [31:0] io_data_in,
    output logic        io_read,
    output logic        io_write,
    input  logic [31:0] io_data_out,
    output logic        busy
);

    localparam logic [1:0] c_st_idle      = 2'd0;
    localparam logic [1:0] c_st_access    = 2'd1;
    localparam logic [1:0] c_st_resp      = 2'd2;
    localparam logic       c_own_cpu      = 1'b0;
    localparam logic       c_own_dma      = 1'b1;
    localparam logic [3:0] c_starve_limit = 4'(STARVE_LIMIT);

    logic [1:0]  r_state;
    logic        r_owner;
    logic        r_last_owner;
    logic [3:0]  r_starve_cnt;
    logic        r_io_read;
    logic        r_io_write;
    logic [23:0] r_io_addr;
    logic [31:0] r_io_data_in;
    logic        r_cpu_ack;
    logic        r_dma_ack;
    logic [31:0] r_cpu_rdata;
    logic [31:0] r_dma_rdata;

    logic        w_cpu_blocked;
    logic        w_starved;
    logic        w_grant_cpu;
    logic        w_grant_dma;
    logic        w_grant;
    logic        w_sel_we;
    logic [23:0] w_sel_addr;
    logic [31:0] w_sel_wdata;
    logic [3:0]  w_starve_next;

    // A locked DMA burst shuts the CPU out even when DMA is momentarily idle.
    always_comb begin
        w_cpu_blocked = dma_lock && (r_last_owner == c_own_dma);
        w_starved     = (r_starve_cnt >= c_starve_limit);
        w_grant_cpu   = cpu_req && !w_cpu_blocked && (!dma_req || w_starved);
        w_grant_dma   = dma_req && !w_grant_cpu;
        w_grant       = w_grant_cpu || w_grant_dma;
        w_sel_we      = w_grant_dma ? dma_we    : cpu_we;
        w_sel_addr    = w_grant_dma ? dma_addr  : cpu_addr;
        w_sel_wdata   = w_grant_dma ? dma_wdata : cpu_wdata;
    end

    always_comb begin
        w_starve_next = 4'd0;
        if (w_grant_dma && cpu_req) begin
            w_starve_next = w_starved ? c_starve_limit : (r_starve_cnt + 4'd1);
        end
    end

    always_ff @(posedge clk_mem or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_st_idle;
            r_owner      <= c_own_cpu;
            r_last_owner <= c_own_cpu;
            r_starve_cnt <= 4'd0;
            r_io_read    <= 1'b0;
            r_io_write   <= 1'b0;
            r_io_addr    <= 24'd0;
            r_io_data_in <= 32'd0;
            r_cpu_ack    <= 1'b0;
            r_dma_ack    <= 1'b0;
        end else begin
            r_cpu_ack <= 1'b0;
            r_dma_ack <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_grant) begin
                        r_state      <= c_st_access;
                        r_owner      <= w_grant_dma ? c_own_dma : c_own_cpu;
                        r_io_addr    <= w_sel_addr;
                        r_io_data_in <= w_sel_wdata;
                        r_io_write   <= w_sel_we;
                        r_io_read    <= !w_sel_we;
                        r_starve_cnt <= w_starve_next;
                    end
                end
                c_st_access: begin
                    r_state      <= c_st_resp;
                    r_io_read    <= 1'b0;
                    r_io_write   <= 1'b0;
                    r_cpu_ack    <= (r_owner == c_own_cpu);
                    r_dma_ack    <= (r_owner == c_own_dma);
                    r_last_owner <= r_owner;
                end
                c_st_resp: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state    <= c_st_idle;
                    r_io_read  <= 1'b0;
                    r_io_write <= 1'b0;
                end
            endcase
        end
    end

    // Read data is captured on the edge that closes the access cycle.
    always_ff @(posedge clk_mem or negedge rst_n) begin
        if (!rst_n) begin
            r_cpu_rdata <= 32'd0;
            r_dma_rdata <= 32'd0;
        end else if ((r_state == c_st_access) && r_io_read) begin
            if (r_owner == c_own_dma) begin
                r_dma_rdata <= io_data_out;
            end else begin
                r_cpu_rdata <= io_data_out;
            end
        end
    end

    assign cpu_ack    = r_cpu_ack;
    assign dma_ack    = r_dma_ack;
    assign cpu_rdata  = r_cpu_rdata;
    assign dma_rdata  = r_dma_rdata;
    assign io_addr    = r_io_addr;
    assign io_data_in = r_io_data_in;
    assign io_read    = r_io_read;
    assign io_write   = r_io_write;
    assign busy       = (r_state != c_st_idle);

endmodule

`default_nettype wire

// File: tb/tb_io_bus_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_io_bus_arbiter
// Brief   : Scoreboard bench for io_bus_arbiter: requester drivers, IO block
//           model, transaction-level reference arbiter and an output monitor.
// Rev     : 1.0  initial release
// ============================================================================
module tb_io_bus_arbiter;

    localparam int STARVE_LIMIT = 4;

    logic        clk_mem = 1'b0;
    logic        rst_n;
    logic        cpu_req = 1'b0, cpu_we = 1'b0, dma_req = 1'b0, dma_we = 1'b0, dma_lock = 1'b0;
    logic [23:0] cpu_addr = '0, dma_addr = '0;
    logic [31:0] cpu_wdata = '0, dma_wdata = '0, io_data_out = '0;
    logic        cpu_ack, dma_ack, io_read, io_write, busy;
    logic [31:0] cpu_rdata, dma_rdata, io_data_in;
    logic [23:0] io_addr;

    always #5 clk_mem = ~clk_mem;

    io_bus_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk_mem(clk_mem), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_lock(dma_lock), .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .io_addr(io_addr), .io_data_in(io_data_in), .io_read(io_read), .io_write(io_write),
        .io_data_out(io_data_out), .busy(busy)
    );

    typedef struct { bit we; logic [23:0] addr; logic [31:0] wdata; } txn_t;
    typedef struct { bit dma; bit we; logic [23:0] addr; logic [31:0] wdata; int cyc; bit seen; } exp_t;

    txn_t        cpu_txq[$], dma_txq[$];
    exp_t        expq[$];
    string       ack_str = "";
    int          ack_cyc[$];
    int          checks = 0, errors = 0, cyc = 0;
    bit          cpu_act = 0, dma_act = 0;
    logic [31:0] io_mem [logic [23:0]];
    logic [31:0] shadow [logic [23:0]];

    function automatic logic [31:0] dflt(logic [23:0] a);
        return {8'hA5, a};
    endfunction

    function automatic logic [31:0] shadow_rd(logic [23:0] a);
        return shadow.exists(a) ? shadow[a] : dflt(a);
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.we    = 1'($urandom_range(0, 1));
        t.addr  = ($urandom_range(0, 3) == 0) ? 24'($urandom) : 24'h100 + 24'(4 * $urandom_range(0, 3));
        t.wdata = $urandom;
        return t;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_str(string name, string act, string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got '%s' expected '%s'", name, act, exp);
        end
    endtask

    task automatic wait_idle(int budget);
        int n = 0;
        while ((cpu_txq.size() != 0 || dma_txq.size() != 0 || cpu_act || dma_act || expq.size() != 0)
               && n < budget) begin
            @(negedge clk_mem);
            n++;
        end
        check("wait_idle_timeout", 64'(n >= budget), 64'd0);
        repeat (2) @(negedge clk_mem);
    endtask

    // Requester drivers: hold req and payload until the matching ack.
    initial begin
        txn_t t;
        forever begin
            @(negedge clk_mem);
            if (!rst_n) cpu_act = 0;
            else begin
                if (cpu_act && cpu_ack) cpu_act = 0;
                if (!cpu_act && cpu_txq.size() != 0) begin
                    t = cpu_txq.pop_front();
                    cpu_we = t.we; cpu_addr = t.addr; cpu_wdata = t.wdata; cpu_act = 1;
                end
            end
            cpu_req = cpu_act;
        end
    end

    initial begin
        txn_t t;
        forever begin
            @(negedge clk_mem);
            if (!rst_n) dma_act = 0;
            else begin
                if (dma_act && dma_ack) dma_act = 0;
                if (!dma_act && dma_txq.size() != 0) begin
                    t = dma_txq.pop_front();
                    dma_we = t.we; dma_addr = t.addr; dma_wdata = t.wdata; dma_act = 1;
                end
            end
            dma_req = dma_act;
        end
    end

    // IO register block: writes land on the strobe edge, reads are combinational on io_addr.
    initial forever begin
        @(posedge clk_mem);
        if (io_write) io_mem[io_addr] = io_data_in;
    end

    initial forever begin
        @(negedge clk_mem);
        io_data_out = io_mem.exists(io_addr) ? io_mem[io_addr] : dflt(io_addr);
    end

    // Reference arbiter: one grant per idle slot, each transaction occupies three edges.
    int  m_left = 0, m_starve = 0;
    bit  m_last_dma = 0, m_cpu_ok, m_dma_wins;
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_mem or negedge rst_n);
            if (!rst_n) begin
                m_left = 0; m_starve = 0; m_last_dma = 0; expq.delete();
            end else begin
                cyc++;
                m_cpu_ok = cpu_req && !(dma_lock && m_last_dma);
                if (m_left > 0) m_left--;
                else if (dma_req || m_cpu_ok) begin
                    m_dma_wins = dma_req && !(m_cpu_ok && m_starve >= STARVE_LIMIT);
                    if (m_dma_wins && cpu_req) m_starve = (m_starve + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_starve + 1;
                    else m_starve = 0;
                    e.dma   = m_dma_wins;
                    e.we    = m_dma_wins ? dma_we : cpu_we;
                    e.addr  = m_dma_wins ? dma_addr : cpu_addr;
                    e.wdata = m_dma_wins ? dma_wdata : cpu_wdata;
                    e.cyc   = cyc;
                    e.seen  = 0;
                    expq.push_back(e);
                    m_left     = 2;
                    m_last_dma = m_dma_wins;
                end
            end
        end
    end

    // Monitor: strobes and acks are compared against the scoreboard queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_mem);
            if (rst_n) begin
                check("busy", 64'(busy), 64'(m_left != 0));
                check("both_strobes", 64'(io_read && io_write), 64'd0);
                check("both_acks", 64'(cpu_ack && dma_ack), 64'd0);
                if (io_read || io_write) begin
                    if (expq.size() == 0) check("spurious_strobe", 64'd1, 64'd0);
                    else begin
                        check("strobe_cycle", 64'(cyc), 64'(expq[0].cyc));
                        check("strobe_repeat", 64'(expq[0].seen), 64'd0);
                        check("io_write", 64'(io_write), 64'(expq[0].we));
                        check("io_addr", 64'(io_addr), 64'(expq[0].addr));
                        if (expq[0].we) check("io_data_in", 64'(io_data_in), 64'(expq[0].wdata));
                        expq[0].seen = 1;
                    end
                end
                if (cpu_ack || dma_ack) begin
                    if (expq.size() == 0) check("spurious_ack", 64'd1, 64'd0);
                    else begin
                        e = expq.pop_front();
                        check("ack_owner_dma", 64'(dma_ack), 64'(e.dma));
                        check("ack_cycle", 64'(cyc), 64'(e.cyc + 1));
                        check("ack_after_strobe", 64'(e.seen), 64'd1);
                        if (e.we) shadow[e.addr] = e.wdata;
                        else if (e.dma) check("dma_rdata", 64'(dma_rdata), 64'(shadow_rd(e.addr)));
                        else check("cpu_rdata", 64'(cpu_rdata), 64'(shadow_rd(e.addr)));
                        ack_str = {ack_str, dma_ack ? "D" : "C"};
                        ack_cyc.push_back(cyc);
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        string exp_s;
        int    n;
        io_mem[24'h104] = 32'h1234_5678;
        shadow[24'h104] = 32'h1234_5678;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk_mem);
        check("rst_cpu_ack", 64'(cpu_ack), 64'd0);
        check("rst_dma_ack", 64'(dma_ack), 64'd0);
        check("rst_io_read", 64'(io_read), 64'd0);
        check("rst_io_write", 64'(io_write), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_io_addr", 64'(io_addr), 64'd0);
        check("rst_io_data_in", 64'(io_data_in), 64'd0);
        check("rst_cpu_rdata", 64'(cpu_rdata), 64'd0);
        check("rst_dma_rdata", 64'(dma_rdata), 64'd0);
        rst_n = 1'b1;

        // CPU write, then CPU read of a preset timer register
        @(posedge clk_mem); #1;
        ack_str = "";
        cpu_txq.push_back('{1'b1, 24'h000100, 32'h00C3_0000});
        wait_idle(50);
        check_str("cpu_write_order", ack_str, "C");
        check("io_mem_written", 64'(io_mem[24'h000100]), 64'h00C3_0000);
        @(posedge clk_mem); #1;
        ack_str = "";
        cpu_txq.push_back('{1'b0, 24'h000104, 32'h0});
        wait_idle(50);
        repeat (4) @(negedge clk_mem);
        check_str("cpu_read_order", ack_str, "C");
        check("cpu_rdata_held", 64'(cpu_rdata), 64'h1234_5678);

        // Simultaneous requests: DMA first, CPU three cycles later
        @(posedge clk_mem); #1;
        ack_str = ""; ack_cyc.delete();
        dma_txq.push_back(rand_txn());
        cpu_txq.push_back(rand_txn());
        wait_idle(50);
        check_str("simul_order", ack_str, "DC");
        if (ack_cyc.size() == 2) check("simul_gap", 64'(ack_cyc[1] - ack_cyc[0]), 64'd3);
        else check("simul_ack_count", 64'(ack_cyc.size()), 64'd2);

        // Starvation guard with both requests held
        @(posedge clk_mem); #1;
        ack_str = "";
        for (int i = 0; i < 8; i++) dma_txq.push_back(rand_txn());
        for (int i = 0; i < 2; i++) cpu_txq.push_back(rand_txn());
        wait_idle(200);
        check_str("starve_order", ack_str, "DDDDCDDDDC");

        // DMA lock: CPU shut out until released
        @(posedge clk_mem); #1;
        ack_str = ""; exp_s = "";
        dma_lock = 1'b1;
        for (int i = 0; i < 20; i++) begin
            dma_txq.push_back(rand_txn());
            exp_s = {exp_s, "D"};
        end
        cpu_txq.push_back(rand_txn());
        n = 0;
        while ((dma_txq.size() != 0 || dma_act || expq.size() != 0) && n < 200) begin
            @(negedge clk_mem);
            n++;
        end
        repeat (6) @(negedge clk_mem);
        check_str("lock_order", ack_str, exp_s);
        check("lock_cpu_waiting", 64'(cpu_act), 64'd1);
        dma_lock = 1'b0;
        wait_idle(50);
        check_str("unlock_order", ack_str, {exp_s, "C"});

        // Randomized traffic with random lock pulses
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk_mem); #1;
            if ($urandom_range(0, 3) == 0 && cpu_txq.size() < 3) cpu_txq.push_back(rand_txn());
            if ($urandom_range(0, 3) == 0 && dma_txq.size() < 3) dma_txq.push_back(rand_txn());
            dma_lock = ($urandom_range(0, 5) == 0);
        end
        dma_lock = 1'b0;
        wait_idle(500);

        // Reset in the middle of a DMA write access
        @(posedge clk_mem); #1;
        ack_str = "";
        dma_txq.push_back('{1'b1, 24'h000108, 32'hDEAD_BEEF});
        n = 0;
        while (!io_write && n < 20) begin
            @(negedge clk_mem);
            n++;
        end
        check("midrst_reached_access", 64'(io_write), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_io_write", 64'(io_write), 64'd0);
        check("midrst_io_read", 64'(io_read), 64'd0);
        check("midrst_busy", 64'(busy), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_mem);
            check("midrst_dma_ack", 64'(dma_ack), 64'd0);
        end
        rst_n = 1'b1;
        @(posedge clk_mem); #1;
        cpu_txq.push_back('{1'b0, 24'h000108, 32'h0});
        wait_idle(50);
        check_str("post_reset_order", ack_str, "C");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
